// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: 8N1 UART transmitter fed by a byte FIFO.
// A write into an idle, empty block makes tx fall one edge later.
module uart_tx_fifo #(
    parameter int CLKS_PER_BIT = 10416,
    parameter int FIFO_DEPTH   = 16,
    parameter int ADDR_W       = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] data_in,
    input  logic       wr_en,
    output logic       full,
    output logic       empty,
    output logic       tx,
    output logic       busy,
    output logic       tx_done
);
    localparam int CW = $clog2(CLKS_PER_BIT);

    typedef enum logic [2:0] {IDLE = 3'd0, START = 3'd1, DATA = 3'd2, STOP = 3'd3} state_t;

    state_t            state, state_next;
    logic [7:0]        mem [FIFO_DEPTH];
    logic [ADDR_W-1:0] wr_ptr, rd_ptr;
    logic [ADDR_W:0]   count;
    logic [CW-1:0]     clk_count;
    logic [2:0]        bit_index, idx_next;
    logic [7:0]        shift_reg;
    logic              wr_ok, pop, bit_done, tx_d;

    assign full     = count == (ADDR_W+1)'(FIFO_DEPTH);
    assign empty    = count == '0;
    assign wr_ok    = wr_en && !full;
    assign pop      = state == IDLE && !empty;
    assign bit_done = clk_count == CW'(CLKS_PER_BIT - 1);

    always_ff @(posedge clk)
        state <= rst ? IDLE : state_next;

    always_comb begin
        state_next = IDLE;
        case (state)
            IDLE:    state_next = empty ? IDLE : START;
            START:   state_next = bit_done ? DATA : START;
            DATA:    state_next = (bit_done && bit_index == 3'd7) ? STOP : DATA;
            STOP:    state_next = bit_done ? IDLE : STOP;
            default: state_next = IDLE;
        endcase
    end

    // tx is registered from next-state values so it switches on the same edge as state
    always_comb begin
        idx_next = state == DATA ? bit_index + {2'b0, bit_done} : 3'd0;
        busy     = state != IDLE;
        tx_done  = state == STOP && bit_done;
        tx_d     = state_next == START ? 1'b0 : state_next == DATA ? shift_reg[idx_next] : 1'b1;
    end

    always_ff @(posedge clk)
        if (wr_ok) mem[wr_ptr] <= data_in;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            clk_count <= '0;
            bit_index <= '0;
            shift_reg <= '0;
            tx        <= 1'b1;
        end else begin
            if (wr_ok) wr_ptr <= wr_ptr + ADDR_W'(1);
            if (pop) begin
                rd_ptr    <= rd_ptr + ADDR_W'(1);
                shift_reg <= mem[rd_ptr];
            end
            count     <= count + {ADDR_W'(0), wr_ok} - {ADDR_W'(0), pop};
            clk_count <= (state == IDLE || bit_done) ? '0 : clk_count + CW'(1);
            bit_index <= idx_next;
            tx        <= tx_d;
        end
    end
endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: directed bench for uart_tx_fifo at 16 clocks per bit.
module tb_uart_tx_fifo;
    logic       clk = 0, rst = 1, wr_en = 0, rx_en = 0;
    logic [7:0] data_in = 0;
    logic       full, empty, tx, busy, tx_done;
    int         checks = 0, errors = 0;
    logic [7:0] rx_q[$];
    logic [7:0] sent[16];

    uart_tx_fifo #(.CLKS_PER_BIT(16)) dut (
        .clk(clk), .rst(rst), .data_in(data_in), .wr_en(wr_en),
        .full(full), .empty(empty), .tx(tx), .busy(busy), .tx_done(tx_done)
    );

    always #5 clk = ~clk;

    // independent 8N1 receiver sampling bit centres
    always begin
        logic [7:0] b;
        @(negedge tx);
        if (rx_en) begin
            repeat (8) @(posedge clk);
            #1;
            if (tx === 1'b0) begin
                for (int k = 0; k < 8; k++) begin
                    repeat (16) @(posedge clk);
                    #1 b[k] = tx;
                end
                repeat (16) @(posedge clk);
                #1;
                if (tx === 1'b1) rx_q.push_back(b);
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] b);
        wr_en = 1;
        data_in = b;
        step();
        wr_en = 0;
    endtask

    task automatic wait_fall(output int n);
        n = 0;
        while (tx !== 1'b0 && n < 400) begin
            step();
            n++;
        end
    endtask

    // called off cycles after the edge where tx fell; ends on the last stop-bit cycle
    task automatic run_frame(input logic [7:0] b, input int off);
        logic [9:0] f;
        int nb, nd;
        f = {1'b1, b, 1'b0};
        nb = 0;
        nd = 0;
        for (int i = off; i < 160; i++) begin
            if (i % 16 == 8) check($sformatf("bit%0d_of_%02h", i / 16, b), 32'(tx), 32'(f[i / 16]));
            nb += int'(busy);
            nd += int'(tx_done);
            if (i < 159) step();
        end
        check("tx_done_last", 32'(tx_done), 1);
        check("tx_done_count", nd, 1);
        check("busy_len", nb, 160 - off);
    endtask

    initial begin
        int n, nlow, ndone;
        logic [7:0] nxt;
        repeat (2) step();
        check("rst_tx", 32'(tx), 1);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(tx_done), 0);
        check("rst_empty", 32'(empty), 1);
        check("rst_full", 32'(full), 0);
        rst = 0;
        repeat (3) step();

        push(8'hA5);
        check("a5_count1", 32'(empty), 0);
        check("a5_tx_before", 32'(tx), 1);
        wait_fall(n);
        check("a5_latency", n, 1);
        check("a5_popped", 32'(empty), 1);
        run_frame(8'hA5, 0);
        repeat (5) step();
        check("a5_idle_tx", 32'(tx), 1);
        check("a5_idle_busy", 32'(busy), 0);

        for (int i = 0; i < 16; i++) begin
            push(8'(i));
            check("burst_not_full", 32'(full), 0);
        end
        run_frame(8'h00, 14);
        for (int i = 1; i < 16; i++) begin
            wait_fall(n);
            check("burst_gap", n, 2);
            if (i == 15) check("burst_empty", 32'(empty), 1);
            run_frame(8'(i), 0);
        end
        repeat (2) step();

        push(8'h80);
        for (int i = 0; i < 16; i++) push(8'h10 + 8'(i));
        check("fill_full", 32'(full), 1);
        check("fill_count", 32'(dut.count), 16);
        push(8'hFF);
        check("drop_full", 32'(full), 1);
        check("drop_count", 32'(dut.count), 16);
        run_frame(8'h80, 16);
        step();
        push(8'hEE);
        check("drop_on_pop_tx", 32'(tx), 0);
        check("drop_on_pop_full", 32'(full), 0);
        check("drop_on_pop_count", 32'(dut.count), 15);
        run_frame(8'h10, 0);
        for (int i = 1; i < 16; i++) begin
            wait_fall(n);
            check("full_gap", n, 2);
            run_frame(8'h10 + 8'(i), 0);
        end
        check("full_drain_empty", 32'(empty), 1);
        repeat (2) step();

        for (int i = 0; i < 6; i++) push(8'h40 + 8'(i));
        check("wrap_count5", 32'(dut.count), 5);
        run_frame(8'h40, 4);
        nxt = 8'h46;
        for (int j = 1; j < 40; j++) begin
            step();
            if (nxt <= 8'h67) begin
                push(nxt);
                nxt++;
                check("wrap_count_hold", 32'(dut.count), 5);
            end else step();
            check("wrap_start", 32'(tx), 0);
            run_frame(8'h40 + 8'(j), 0);
        end
        check("wrap_empty", 32'(empty), 1);
        repeat (2) step();

        push(8'h5A);
        push(8'h77);
        repeat (72) step();
        rst = 1;
        step();
        rst = 0;
        check("midrst_tx", 32'(tx), 1);
        check("midrst_empty", 32'(empty), 1);
        check("midrst_busy", 32'(busy), 0);
        check("midrst_done", 32'(tx_done), 0);
        nlow = 0;
        ndone = 0;
        for (int i = 0; i < 200; i++) begin
            step();
            nlow += int'(tx !== 1'b1);
            ndone += int'(tx_done);
        end
        check("midrst_quiet_tx", nlow, 0);
        check("midrst_no_done", ndone, 0);
        push(8'h3C);
        wait_fall(n);
        check("3c_latency", n, 1);
        run_frame(8'h3C, 0);
        repeat (2) step();

        rx_q.delete();
        rx_en = 1;
        for (int i = 0; i < 16; i++) begin
            sent[i] = 8'($urandom_range(0, 255));
            push(sent[i]);
        end
        n = 0;
        while (!(empty && !busy) && n < 3000) begin
            step();
            n++;
        end
        check("loop_timeout", 32'(n < 3000), 1);
        repeat (20) step();
        check("loop_count", rx_q.size(), 16);
        for (int i = 0; i < 16; i++) check($sformatf("loop_byte%0d", i), 32'(rx_q[i]), 32'(sent[i]));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
